// File: rtl/fibo_pkg.sv
// Shared command and FSM state encodings for the Fibonacci stream generator.
package fibo_pkg;

  typedef enum logic [1:0] {
    CMD_HOLD    = 2'b00,
    CMD_STEP    = 2'b01,
    CMD_RESTART = 2'b10,
    CMD_LOAD    = 2'b11
  } cmd_e;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_SAT = 1'b1
  } state_e;

endpackage : fibo_pkg

// File: rtl/fibo_step.sv
// Combinational next-term arithmetic: wrap or clamp on carry, hold while saturated.
module fibo_step
  import fibo_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter bit          SATURATE = 1'b0
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  state_e           state_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             carry_o,
  output state_e           state_o
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, a_i} + {1'b0, b_i};

  always_comb begin
    a_o     = a_i;
    b_o     = b_i;
    carry_o = 1'b0;
    state_o = state_i;
    if (state_i == ST_RUN) begin
      carry_o = sum[WIDTH];
      b_o     = a_i;
      if (sum[WIDTH] && SATURATE) begin
        a_o     = '1;
        state_o = ST_SAT;
      end else begin
        a_o = sum[WIDTH-1:0];
      end
    end
  end

endmodule : fibo_step

// File: rtl/fibo_stream_gen.sv
// Fibonacci-style term source with seed load/restart, valid/ready output,
// sticky overflow and a free-running term counter.
module fibo_stream_gen
  import fibo_pkg::*;
#(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] SEED_A   = WIDTH'(1),
  parameter logic [WIDTH-1:0] SEED_B   = WIDTH'(0),
  parameter bit               SATURATE = 1'b0,
  parameter int unsigned      CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       cmd,
  input  logic [WIDTH-1:0] load_a,
  input  logic [WIDTH-1:0] load_b,
  output logic             cmd_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] term_idx
);

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;

  logic [WIDTH-1:0] step_a, step_b;
  logic             step_carry;
  state_e           step_state;
  cmd_e             cmd_c;

  assign cmd_c     = cmd_e'(cmd);
  assign cmd_ready = !valid_q || out_ready;

  fibo_step #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_step (
    .a_i     (a_q),
    .b_i     (b_q),
    .state_i (state_q),
    .a_o     (step_a),
    .b_o     (step_b),
    .carry_o (step_carry),
    .state_o (step_state)
  );

  // Flush commands win over STEP; a same-cycle transfer has already been seen.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    unique case (cmd_c)
      CMD_RESTART, CMD_LOAD: begin
        a_d     = (cmd_c == CMD_LOAD) ? load_a : SEED_A;
        b_d     = (cmd_c == CMD_LOAD) ? load_b : SEED_B;
        valid_d = 1'b0;
        ovf_d   = 1'b0;
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      CMD_STEP: begin
        if (cmd_ready) begin
          a_d     = step_a;
          b_d     = step_b;
          state_d = step_state;
          ovf_d   = ovf_q || step_carry;
          valid_d = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q     <= SEED_A;
      b_q     <= SEED_B;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      state_q <= ST_RUN;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = a_q;
  assign out_ovf   = ovf_q;
  assign term_idx  = cnt_q;

endmodule : fibo_stream_gen

// File: doc/fibo_stream_gen.md
Name: fibo_stream_gen

Overview:
- Parametrised Fibonacci-style term generator. Successor to the fixed 8-bit, one-input-bit sequence core.
- Adds configurable width and seeds, runtime seed load and restart, a valid/ready output handshake with backpressure, overflow detection with a wrap or saturate mode, and a term counter.
- Sits as a leaf stimulus/sequence source feeding streaming datapaths; driven by a small command interface.

Parameters:
- WIDTH, 8, data width of terms and seeds (>=2).
- SEED_A, 1, reset/restart value of current term register A (WIDTH bits).
- SEED_B, 0, reset/restart value of previous term register B (WIDTH bits).
- SATURATE, 0, 0 = wrap modulo 2^WIDTH on overflow; 1 = clamp at all-ones and enter SAT.
- CNT_W, 16, width of term counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- cmd  in  2  00 HOLD, 01 STEP, 10 RESTART, 11 LOAD.
- load_a  in  WIDTH  new A value, sampled on LOAD.
- load_b  in  WIDTH  new B value, sampled on LOAD.
- cmd_ready  out  1  STEP is accepted this cycle; equals !out_valid | out_ready.
- out_valid  out  1  out_data holds an unconsumed term.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  WIDTH  most recently generated term (registered A).
- out_ovf  out  1  sticky: an overflow has occurred since last RESTART/LOAD.
- term_idx  out  CNT_W  number of STEPs accepted since last RESTART/LOAD; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=0, async):
  - A=SEED_A, B=SEED_B, state RUN.
  - out_valid=0, out_data=SEED_A, out_ovf=0, term_idx=0.
  - Registers stay in reset while rst=0; release is sampled on clk.
- State registers: A (current term), B (previous term), out_valid, ovf, term_idx, and a 2-state FSM {RUN, SAT}.
- Output handshake:
  - A transfer occurs when out_valid & out_ready.
  - out_valid clears after a transfer unless a STEP is accepted in the same cycle.
  - out_data is stable while out_valid=1 and out_ready=0.
- STEP is accepted iff cmd=01 & cmd_ready.
  - sum = A + B computed at WIDTH+1 bits; carry = sum[WIDTH].
  - RUN, carry=0: A<=sum[WIDTH-1:0], B<=A.
  - RUN, carry=1, SATURATE=0: same update (wrap), ovf<=1.
  - RUN, carry=1, SATURATE=1: A<=all-ones, B<=A, ovf<=1, FSM->SAT.
  - SAT: A and B hold (A stays all-ones).
  - In every case: out_valid<=1, term_idx<=term_idx+1.
  - Latency is 1 cycle: the new term is visible on out_data the cycle after acceptance.
- STEP with cmd_ready=0 is ignored (no state change). The master must hold cmd until cmd_ready=1.
- RESTART (10):
  - Always accepted regardless of out_ready.
  - A=SEED_A, B=SEED_B, ovf=0, term_idx=0, out_valid=0, FSM->RUN.
  - A pending unconsumed term is discarded.
- LOAD (11): as RESTART, but A=load_a, B=load_b.
- HOLD (00): no change except the handshake clear.
- Priority: RESTART/LOAD > STEP. A same-cycle transfer still completes from the consumer's view (data seen that cycle) before the flush.
- term_idx wrap: at 2^CNT_W-1 a STEP yields 0; no flag.
- Zero seeds (A=B=0): the generator emits 0 forever; this is legal.

Decomposition:
- Package fibo_pkg: cmd_e enum (CMD_HOLD, CMD_STEP, CMD_RESTART, CMD_LOAD) and state_e (ST_RUN, ST_SAT).
- One natural sub-module: fibo_step (combinational; A, B, SATURATE, state → next A, next B, carry, next state) to isolate the arithmetic for unit checks.

Test Plan:
- Reset, then 13 STEPs with WIDTH=8, defaults, out_ready=1 → out_data 1,2,3,5,8,13,21,34,55,89,144,233,121; out_ovf rises on the 13th term; term_idx=13.
- Same run with SATURATE=1 → 13th term 255 and FSM in SAT; further STEPs output 255, term_idx keeps counting, out_ovf=1.
- Backpressure: STEP with out_ready=0 → out_valid=1, data 1; STEP held 3 cycles → cmd_ready=0, out_data stays 1, term_idx stays 1; out_ready=1 → next cycle out_data 2.
- LOAD load_a=100, load_b=50, then 2 STEPs → out_data 150, then 250; ovf=0; term_idx=2.
- RESTART while out_valid=1, out_ready=0 → next cycle out_valid=0, term_idx=0, out_ovf=0; STEP → out_data 1.
- Assert rst=0 mid-sequence between clock edges → outputs take reset values immediately (out_valid=0, out_data=1), without waiting for clk.
